// File: rtl/chg_event_logger.sv
// chg_event_logger: samples buses r and b on enabled clocks, turns every change
// against the previous sample into a record {time, r, b, flags} and buffers the
// records in a first-word-fall-through FIFO drained over valid/ready.
// Optional feature macro: CHG_LOG_TS_EN (free-running timestamp counter and
// per-record timestamp storage). Without it ev_time is tied to 0.
module chg_event_logger #(
    parameter int DW = 32,
    parameter int TW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] r_in,
    input  logic [DW-1:0] b_in,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [TW-1:0] ev_time,
    output logic [DW-1:0] ev_r,
    output logic [DW-1:0] ev_b,
    output logic [1:0]    ev_flags,
    output logic [AW:0]   level,
    output logic          full,
    output logic [7:0]    drop_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam int PW    = 2 * DW + 2;
`ifdef CHG_LOG_TS_EN
    localparam int EW    = TW + PW;
`else
    localparam int EW    = PW;
`endif
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];

    logic [DW-1:0] r_prev_q, r_prev_d;
    logic [DW-1:0] b_prev_q, b_prev_d;
    logic          primed_q, primed_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ev_valid_q, full_q;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
`ifdef CHG_LOG_TS_EN
    logic [TW-1:0] time_q, time_d;
`endif

    logic          cr, cb, push, pop, push_ok, drop;
    logic [EW-1:0] wr_entry, head;

    // Change detection, FIFO push/pop arbitration and next-state computation
    always_comb begin
        cr = 1'b0;
        cb = 1'b0;
        if (en && primed_q) begin
            cr = (r_in != r_prev_q);
            cb = (b_in != b_prev_q);
        end
        push    = cr | cb;
        pop     = ev_valid_q & ev_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts
        push_ok = push & (~full_q | pop);
        drop    = push & full_q & ~pop;

        r_prev_d = en ? r_in : r_prev_q;
        b_prev_d = en ? b_in : b_prev_q;
        primed_d = primed_q | en;

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push_ok && !pop)
            level_d = level_q + (AW + 1)'(1);
        else if (!push_ok && pop)
            level_d = level_q - (AW + 1)'(1);

        drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;

`ifdef CHG_LOG_TS_EN
        time_d   = time_q + TW'(1);
        wr_entry = {time_q, r_in, b_in, cb, cr};
`else
        wr_entry = {r_in, b_in, cb, cr};
`endif
    end

    // Control state: sampling history, FIFO pointers, occupancy and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_q   <= '0;
            b_prev_q   <= '0;
            primed_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ev_valid_q <= 1'b0;
            full_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            r_prev_q   <= r_prev_d;
            b_prev_q   <= b_prev_d;
            primed_q   <= primed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ev_valid_q <= (level_d != '0);
            full_q     <= (level_d == LVL_FULL);
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef CHG_LOG_TS_EN
    // Free-running timestamp, advances every edge independent of en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            time_q <= '0;
        else
            time_q <= time_d;
    end
`endif

    // Record storage; contents are only observed through a valid head pointer
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head     = mem_q[rd_ptr_q];
    assign ev_valid = ev_valid_q;
    assign level    = level_q;
    assign full     = full_q;
    assign drop_cnt = drop_cnt_q;
    assign ev_flags = ev_valid_q ? head[1:0] : 2'b00;
    assign ev_b     = ev_valid_q ? head[DW+1:2] : '0;
    assign ev_r     = ev_valid_q ? head[PW-1:DW+2] : '0;
`ifdef CHG_LOG_TS_EN
    assign ev_time  = ev_valid_q ? head[EW-1:PW] : '0;
`else
    assign ev_time  = '0;
`endif

endmodule

// File: tb/tb_chg_event_logger.sv
// Self-checking bench for chg_event_logger: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_chg_event_logger;

    localparam int DW = 32;
    localparam int TW = 16;
    localparam int AW = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] r_in, b_in;
    logic          ev_valid, ev_ready;
    logic [TW-1:0] ev_time;
    logic [DW-1:0] ev_r, ev_b;
    logic [1:0]    ev_flags;
    logic [AW:0]   level;
    logic          full;
    logic [7:0]    drop_cnt;

    // Small instance used only for timestamp wrap behaviour
    logic          rst2_n, en2, ready2, valid2, full2;
    logic [7:0]    r2, b2, evr2, evb2, drop2;
    logic [3:0]    time2;
    logic [1:0]    flags2;
    logic [3:0]    level2;

    int checks = 0;
    int failures = 0;

    chg_event_logger #(.DW(DW), .TW(TW), .AW(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .r_in(r_in), .b_in(b_in),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_time(ev_time),
        .ev_r(ev_r), .ev_b(ev_b), .ev_flags(ev_flags),
        .level(level), .full(full), .drop_cnt(drop_cnt)
    );

    chg_event_logger #(.DW(8), .TW(4), .AW(3)) u_wrap (
        .clk(clk), .rst_n(rst2_n), .en(en2), .r_in(r2), .b_in(b2),
        .ev_valid(valid2), .ev_ready(ready2), .ev_time(time2),
        .ev_r(evr2), .ev_b(evb2), .ev_flags(flags2),
        .level(level2), .full(full2), .drop_cnt(drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [DW-1:0] r;
        logic [DW-1:0] b;
        logic [1:0]  f;
    } rec_t;

    rec_t          q[$];
    int            m_time;
    bit            m_primed;
    logic [DW-1:0] m_r, m_b;
    int            m_drops;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_time   = 0;
        m_primed = 0;
        m_r      = '0;
        m_b      = '0;
        m_drops  = 0;
    endtask

    task automatic compare();
        chk("valid", ev_valid, q.size() > 0);
        chk("level", level, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("drop_cnt", drop_cnt, m_drops);
        if (q.size() > 0) begin
            chk("head_r", ev_r, q[0].r);
            chk("head_b", ev_b, q[0].b);
            chk("head_flags", ev_flags, q[0].f);
`ifdef CHG_LOG_TS_EN
            chk("head_time", ev_time, q[0].t);
`else
            chk("head_time", ev_time, 0);
`endif
        end else begin
            chk("idle_r", ev_r, 0);
            chk("idle_b", ev_b, 0);
            chk("idle_flags", ev_flags, 0);
            chk("idle_time", ev_time, 0);
        end
    endtask

    // One clock edge: apply the model's rules to the sampled inputs, then compare
    task automatic step();
        bit   pop, push;
        rec_t nr;
        @(posedge clk);
        pop  = ev_ready && (q.size() > 0);
        push = 0;
        if (en) begin
            if (m_primed && (r_in != m_r || b_in != m_b)) begin
                nr.t = m_time;
                nr.r = r_in;
                nr.b = b_in;
                nr.f = {b_in != m_b, r_in != m_r};
                if (q.size() < DEPTH || pop) push = 1;
                else if (m_drops < 255) m_drops++;
            end
            m_primed = 1;
            m_r = r_in;
            m_b = b_in;
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(nr);
        m_time = (m_time + 1) % (1 << TW);
        @(negedge clk);
        compare();
    endtask

    initial begin
        int nrec;
        rst_n = 0; en = 0; r_in = '0; b_in = '0; ev_ready = 0;
        rst2_n = 0; en2 = 0; r2 = '0; b2 = '0; ready2 = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", ev_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_r", ev_r, 0);
        chk("rst_time", ev_time, 0);

        // Single timestamped change on the 11th edge after release
        en = 1; ev_ready = 1;
        rst_n = 1;
        step();
        chk("baseline_no_rec", level, 0);
        repeat (9) step();
        r_in = 5;
        step();
        chk("t1_r", ev_r, 5);
        chk("t1_flags", ev_flags, 2'b01);
`ifdef CHG_LOG_TS_EN
        chk("t1_time", ev_time, 10);
`endif

        // Simultaneous change, pushed on the same edge the previous head pops
        r_in = 6; b_in = 3;
        step();
        chk("sim_flags", ev_flags, 2'b11);
        chk("sim_r", ev_r, 6);
        chk("sim_b", ev_b, 3);
        chk("sim_level", level, 1);
        step();
        chk("sim_drained", level, 0);

        // Overflow: ten changes with the consumer stalled
        ev_ready = 0;
        for (int i = 1; i <= 10; i++) begin
            r_in = i;
            step();
        end
        chk("ovf_full", full, 1);
        chk("ovf_level", level, 8);
        chk("ovf_drop", drop_cnt, 2);
        ev_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_order", ev_r, i);
            step();
        end
        chk("ovf_empty", level, 0);

        // Push and pop on the same edge while full
        ev_ready = 0;
        for (int i = 20; i < 28; i++) begin
            r_in = i;
            step();
        end
        chk("pp_full", level, 8);
        ev_ready = 1; r_in = 28;
        step();
        chk("pp_drop", drop_cnt, 2);
        chk("pp_level", level, 8);
        for (int i = 21; i <= 28; i++) begin
            chk("pp_order", ev_r, i);
            step();
        end

        // Reset mid-operation with records queued
        ev_ready = 0;
        for (int i = 30; i < 33; i++) begin
            r_in = i;
            step();
        end
        chk("mid_level", level, 3);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", ev_valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_full", full, 0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        r_in = 33;
        step();
        chk("post_rst_baseline", level, 0);
        r_in = 34;
        step();

        // Enable gating: changes while en=0 collapse into one net record
        ev_ready = 1;
        step();
        ev_ready = 0; en = 0;
        r_in = 40; step();
        r_in = 41; step();
        b_in = 7;  step();
        chk("gate_none", level, 0);
        en = 1;
        step();
        chk("gate_one", level, 1);
        chk("gate_flags", ev_flags, 2'b11);
        ev_ready = 1;
        step();

        // Random traffic with bursty consumer stalls
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 15) == 0) ev_ready = ~ev_ready;
            if ($urandom_range(0, 1) != 0) r_in = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) b_in = $urandom_range(0, 3);
            step();
        end

        // Drop counter saturation
        en = 1; ev_ready = 0;
        for (int i = 0; i < 280; i++) begin
            r_in = 1000 + i;
            step();
        end
        chk("sat_drop", drop_cnt, 255);
        ev_ready = 1;
        repeat (10) step();
        chk("sat_empty", level, 0);

        // Timestamp wrap on a 4-bit counter, changes every 5 cycles
        nrec = 0;
        @(negedge clk);
        en2 = 1; ready2 = 1; rst2_n = 1;
        for (int e = 1; e <= 24; e++) begin
            if (e == 13 || e == 18 || e == 23) r2 = 8'(e);
            @(posedge clk);
            @(negedge clk);
            if (valid2) begin
                nrec++;
`ifdef CHG_LOG_TS_EN
                chk("wrap_time", time2, (e - 1) % 16);
`else
                chk("wrap_time", time2, 0);
`endif
                chk("wrap_r", evr2, e);
            end
        end
        chk("wrap_count", nrec, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
